// File: rtl/ws2812_pkg.sv
// Shared types and helpers for the WS2812 strip controller.
package ws2812_pkg;

  // One pixel in the order the LEDs expect it on the wire.
  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StSend,
    StDrain,
    StLatch
  } state_e;

  // Number of clock cycles in the 50 us reset/latch gap.
  function automatic int unsigned dly_res(input int unsigned clk_speed);
    return (clk_speed / 1_000_000) * 50;
  endfunction

  // (c * (br + 1)) >> 8: br = 0xFF is identity, br = 0x00 blanks the channel.
  function automatic logic [7:0] scale8(input logic [7:0] c, input logic [7:0] br);
    logic [15:0] prod;
    prod = {8'd0, c} * ({8'd0, br} + 16'd1);
    return prod[15:8];
  endfunction

  function automatic grb_t scale_grb(input grb_t px, input logic [7:0] br);
    grb_t o;
    o.g = scale8(px.g, br);
    o.r = scale8(px.r, br);
    o.b = scale8(px.b, br);
    return o;
  endfunction

endpackage

// File: rtl/ws2812_strip_ctrl_if.sv
// Pixel stream between the frame controller and the downstream bit serializer.
interface ws2812_strip_ctrl_if;
  logic        tx_valid;
  logic [23:0] tx_grb;
  logic        tx_ready;
  logic        tx_idle;

  modport master (
    output tx_valid,
    output tx_grb,
    input  tx_ready,
    input  tx_idle
  );

  modport slave (
    input  tx_valid,
    input  tx_grb,
    output tx_ready,
    output tx_idle
  );
endinterface

// File: rtl/ws2812_pixbuf.sv
// Read-first 1R1W synchronous RAM holding the pixel buffer.
module ws2812_pixbuf #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 24,
  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  // Non-blocking read of the old contents gives read-first on address collision.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ws2812_strip_ctrl.sv
// Frame controller: streams the brightness-scaled pixel buffer to the serializer,
// then holds the latch gap before reporting frame completion.
module ws2812_strip_ctrl
  import ws2812_pkg::*;
#(
  parameter int unsigned CLK_SPEED  = 27_000_000,
  parameter int unsigned NUM_LEDS   = 16,
  parameter int unsigned REFRESH_HZ = 0,
  localparam int unsigned AddrW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pix_we,
  input  logic [AddrW-1:0]     pix_addr,
  input  logic [7:0]           pix_r,
  input  logic [7:0]           pix_g,
  input  logic [7:0]           pix_b,
  input  logic [7:0]           bright,
  input  logic                 show,
  output logic                 busy,
  output logic                 frame_done,
  ws2812_strip_ctrl_if.master  tx
);

  localparam int unsigned DlyRes  = dly_res(CLK_SPEED);
  localparam logic [15:0] DlyLast = 16'(DlyRes - 1);
  localparam logic [AddrW-1:0] LastIdx = AddrW'(NUM_LEDS - 1);

  state_e           state_q, state_d;
  logic [AddrW-1:0] idx_q, idx_d;
  logic [7:0]       bright_q, bright_d;
  logic             pending_q, pending_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             tx_valid_q, tx_valid_d;
  grb_t             tx_grb_q, tx_grb_d;
  logic             frame_done_q, frame_done_d;

  logic             tick;
  logic             start;
  logic             buf_we;
  grb_t             buf_wdata;
  logic [23:0]      buf_rdata;

  // Auto-refresh period counter, free-running from reset.
  if (REFRESH_HZ > 0) begin : g_tick
    localparam int unsigned Period = CLK_SPEED / REFRESH_HZ;
    localparam logic [31:0] PeriodLast = 32'(Period - 1);
    logic [31:0] tick_cnt_q;

    // Wrap at the period boundary; the wrap cycle is the tick.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tick_cnt_q <= '0;
      end else if (tick_cnt_q == PeriodLast) begin
        tick_cnt_q <= '0;
      end else begin
        tick_cnt_q <= tick_cnt_q + 32'd1;
      end
    end

    assign tick = (tick_cnt_q == PeriodLast);
  end else begin : g_no_tick
    assign tick = 1'b0;
  end

  // show and tick in the same cycle merge into one start.
  assign start = show | tick;

  // Writes beyond the chain length are dropped.
  assign buf_we    = pix_we && (32'(pix_addr) < NUM_LEDS);
  assign buf_wdata = '{g: pix_g, r: pix_r, b: pix_b};

  ws2812_pixbuf #(
    .Depth (NUM_LEDS),
    .Width (24)
  ) u_pixbuf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (pix_addr),
    .wdata (buf_wdata),
    .raddr (idx_q),
    .rdata (buf_rdata)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      bright_q     <= '0;
      pending_q    <= 1'b0;
      cnt_q        <= '0;
      tx_valid_q   <= 1'b0;
      tx_grb_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      bright_q     <= bright_d;
      pending_q    <= pending_d;
      cnt_q        <= cnt_d;
      tx_valid_q   <= tx_valid_d;
      tx_grb_q     <= tx_grb_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state logic for the frame sequencer and its datapath.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    bright_d     = bright_q;
    pending_d    = pending_q;
    cnt_d        = cnt_q;
    tx_valid_d   = tx_valid_q;
    tx_grb_d     = tx_grb_q;
    frame_done_d = 1'b0;

    // Starts arriving mid-frame collapse into a single pending request.
    if (start && (state_q != StIdle)) begin
      pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StFetch;
          idx_d    = '0;
          bright_d = bright;
        end
      end

      // RAM address is idx_q; registered read data lands in the first SEND cycle.
      StFetch: begin
        state_d = StSend;
      end

      StSend: begin
        if (!tx_valid_q) begin
          tx_valid_d = 1'b1;
          tx_grb_d   = scale_grb(grb_t'(buf_rdata), bright_q);
        end else if (tx.tx_ready) begin
          tx_valid_d = 1'b0;
          if (idx_q == LastIdx) begin
            state_d = StDrain;
          end else begin
            idx_d   = idx_q + AddrW'(1);
            state_d = StFetch;
          end
        end
      end

      StDrain: begin
        if (tx.tx_idle) begin
          state_d = StLatch;
          cnt_d   = '0;
        end
      end

      StLatch: begin
        if (cnt_q == DlyLast) begin
          frame_done_d = 1'b1;
          // A start landing in this very cycle is treated as pending too.
          if (pending_q || start) begin
            pending_d = 1'b0;
            state_d   = StFetch;
            idx_d     = '0;
            bright_d  = bright;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy        = (state_q != StIdle);
  assign frame_done  = frame_done_q;
  assign tx.tx_valid = tx_valid_q;
  assign tx.tx_grb   = tx_grb_q;

endmodule

// File: tb/tb_ws2812_strip_ctrl.sv
// Self-checking bench for ws2812_strip_ctrl (NUM_LEDS=4, 27 MHz).
module tb_ws2812_strip_ctrl;

  typedef struct {
    logic [23:0] rgb;
    logic [7:0]  br;
    logic [23:0] exp_grb;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pix_we = 1'b0;
  logic [1:0]  pix_addr = '0;
  logic [7:0]  pix_r = '0;
  logic [7:0]  pix_g = '0;
  logic [7:0]  pix_b = '0;
  logic [7:0]  bright = 8'hFF;
  logic        show = 1'b0;
  logic        busy;
  logic        frame_done;
  logic        tx_ready = 1'b1;
  logic        tx_idle = 1'b1;
  logic        tx_valid;
  logic [23:0] tx_grb;

  int          n_vec = 0;
  int          n_err = 0;
  int          hs_cnt = 0;
  logic [23:0] sb [$];
  logic        hold_prev = 1'b0;
  logic [23:0] grb_prev = '0;
  vec_t        vecs [8];

  ws2812_strip_ctrl_if tx_if ();

  assign tx_if.tx_ready = tx_ready;
  assign tx_if.tx_idle  = tx_idle;
  assign tx_valid       = tx_if.tx_valid;
  assign tx_grb         = tx_if.tx_grb;

  ws2812_strip_ctrl #(
    .CLK_SPEED  (27_000_000),
    .NUM_LEDS   (4),
    .REFRESH_HZ (0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_we     (pix_we),
    .pix_addr   (pix_addr),
    .pix_r      (pix_r),
    .pix_g      (pix_g),
    .pix_b      (pix_b),
    .bright     (bright),
    .show       (show),
    .busy       (busy),
    .frame_done (frame_done),
    .tx         (tx_if)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Scoreboard pop on every handshake, plus hold-stability check under back-pressure.
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_prev) begin
        n_vec++;
        if (!(tx_valid === 1'b1 && tx_grb === grb_prev)) begin
          n_err++;
          $display("FAIL hold: valid %b grb %h, required valid 1 grb %h", tx_valid, tx_grb,
                   grb_prev);
        end
      end
      if (tx_valid === 1'b1 && tx_ready) begin
        hs_cnt++;
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL extra_pixel: got %h, required none", tx_grb);
        end else begin
          logic [23:0] e;
          e = sb.pop_front();
          if (tx_grb !== e) begin
            n_err++;
            $display("FAIL pixel: got %h, required %h", tx_grb, e);
          end
        end
      end
      hold_prev = (tx_valid === 1'b1) && !tx_ready;
      grb_prev  = tx_grb;
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_pix(input int a, input logic [23:0] rgb);
    @(posedge clk);
    #1;
    pix_we   = 1'b1;
    pix_addr = 2'(a);
    pix_r    = rgb[23:16];
    pix_g    = rgb[15:8];
    pix_b    = rgb[7:0];
    @(posedge clk);
    #1;
    pix_we = 1'b0;
  endtask

  task automatic load4(input logic [23:0] p0, input logic [23:0] p1, input logic [23:0] p2,
                       input logic [23:0] p3);
    write_pix(0, p0);
    write_pix(1, p1);
    write_pix(2, p2);
    write_pix(3, p3);
  endtask

  // Leaves the caller just after the edge that samples show.
  task automatic pulse_show;
    @(posedge clk);
    #1 show = 1'b1;
    @(posedge clk);
    #1 show = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 5000) begin
      @(negedge clk);
      n++;
      if (frame_done === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL %s: frame_done absent after 5000 cycles, required a pulse", name);
    end
  endtask

  task automatic wait_hs(input int target, input string name);
    int n;
    n = 0;
    while (hs_cnt < target && n < 200) begin
      @(posedge clk);
      n++;
    end
    check(name, 32'(hs_cnt), 32'(target));
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx_valid !== 1'b1 && n < 50);
    check(name, 32'(tx_valid), 32'd1);
  endtask

  initial begin
    int base;
    int n;
    int fd;
    bit seen;
    bit busy_ok;
    bit extra;

    vecs[0] = '{24'h112233, 8'hFF, 24'h221133};
    vecs[1] = '{24'hFFFFFF, 8'h7F, 24'h7F7F7F};
    vecs[2] = '{24'hFFFFFF, 8'h00, 24'h000000};
    vecs[3] = '{24'h804020, 8'h7F, 24'h204010};
    vecs[4] = '{24'h01FF80, 8'h00, 24'h000000};
    vecs[5] = '{24'h123456, 8'hFF, 24'h341256};
    vecs[6] = '{24'hC8640A, 8'h3F, 24'h193202};
    vecs[7] = '{24'hFF0001, 8'hFE, 24'h00FE00};

    // Reset values, observed without any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst frame_done", 32'(frame_done), 32'd0);
    check("rst tx_valid", 32'(tx_valid), 32'd0);
    check("rst tx_grb", 32'(tx_grb), 32'd0);
    tick_n(3);
    rst_n = 1'b1;
    tick_n(2);

    // Brightness table; bright is disturbed mid-frame and must not matter.
    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < 4; p++) write_pix(p, vecs[i].rgb);
      bright = vecs[i].br;
      repeat (4) sb.push_back(vecs[i].exp_grb);
      pulse_show;
      tick_n(4);
      bright = ~vecs[i].br;
      wait_done($sformatf("vec%0d done", i));
      tick_n(2);
    end

    // Single frame: latency and exact latch gap.
    bright  = 8'hFF;
    tx_idle = 1'b0;
    load4(24'h112233, 24'h445566, 24'h778899, 24'hAABBCC);
    sb.push_back(24'h221133);
    sb.push_back(24'h554466);
    sb.push_back(24'h887799);
    sb.push_back(24'hBBAACC);
    base = hs_cnt;
    pulse_show;
    @(negedge clk);
    check("lat busy k", 32'(busy), 32'd1);
    check("lat valid k", 32'(tx_valid), 32'd0);
    @(negedge clk);
    check("lat valid k+1", 32'(tx_valid), 32'd0);
    @(negedge clk);
    check("lat valid k+2", 32'(tx_valid), 32'd1);
    check("lat grb k+2", 32'(tx_grb), 32'h221133);
    wait_hs(base + 4, "single hs count");
    tick_n(3);
    check("drain busy", 32'(busy), 32'd1);
    check("drain valid", 32'(tx_valid), 32'd0);
    tx_idle = 1'b1;
    @(posedge clk);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 3000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (frame_done === 1'b1) seen = 1'b1;
    end
    check("latch gap cycles", 32'(n), 32'd1350);
    @(negedge clk);
    check("done one cycle", 32'(frame_done), 32'd0);
    check("idle busy", 32'(busy), 32'd0);
    tick_n(2);

    // Back-pressure on pixel 2.
    sb.push_back(24'h221133);
    sb.push_back(24'h554466);
    sb.push_back(24'h887799);
    sb.push_back(24'hBBAACC);
    base = hs_cnt;
    pulse_show;
    wait_hs(base + 2, "bp first two");
    #1 tx_ready = 1'b0;
    wait_valid("bp pixel2 valid");
    check("bp pixel2 grb", 32'(tx_grb), 32'h887799);
    repeat (10) @(posedge clk);
    #1 tx_ready = 1'b1;
    wait_done("bp done");
    check("bp hs count", 32'(hs_cnt), 32'(base + 4));
    tick_n(2);

    // Overlapping requests: three shows mid-frame give exactly one extra frame.
    repeat (8) sb.push_back(24'h0);
    for (int k = 0; k < 2; k++) begin
      sb[k * 4 + 0] = 24'h221133;
      sb[k * 4 + 1] = 24'h554466;
      sb[k * 4 + 2] = 24'h887799;
      sb[k * 4 + 3] = 24'hBBAACC;
    end
    pulse_show;
    wait_valid("ovl first valid");
    for (int k = 0; k < 3; k++) begin
      pulse_show;
      tick_n(2);
    end
    fd = 0;
    n = 0;
    busy_ok = 1'b1;
    while (fd < 2 && n < 6000) begin
      @(negedge clk);
      n++;
      if (frame_done === 1'b1) begin
        fd++;
        if (fd == 1) begin
          check("ovl busy at done1", 32'(busy), 32'd1);
          @(negedge clk);
          @(negedge clk);
          check("ovl restart latency", 32'(tx_valid), 32'd1);
          n += 2;
        end
      end else if (busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
    end
    check("ovl frame_done count", 32'(fd), 32'd2);
    check("ovl busy held", 32'(busy_ok), 32'd1);
    @(negedge clk);
    check("ovl busy after", 32'(busy), 32'd0);
    extra = 1'b0;
    repeat (1600) begin
      @(negedge clk);
      if (frame_done !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0) extra = 1'b1;
    end
    check("ovl no third frame", 32'(extra), 32'd0);
    check("ovl sb empty", 32'(sb.size()), 32'd0);

    // Writes during a frame: unsent pixel 3 updates now, sent pixel 0 next frame.
    tick_n(1);
    sb.push_back(24'h221133);
    sb.push_back(24'h554466);
    sb.push_back(24'h887799);
    sb.push_back(24'hFF0000);
    base = hs_cnt;
    pulse_show;
    wait_hs(base + 1, "wr first hs");
    #1 tx_ready = 1'b0;
    wait_valid("wr pixel1 valid");
    check("wr pixel1 grb", 32'(tx_grb), 32'h554466);
    write_pix(3, 24'h00FF00);
    write_pix(0, 24'h0000FF);
    tx_ready = 1'b1;
    wait_done("wr frame1 done");
    sb.push_back(24'h0000FF);
    sb.push_back(24'h554466);
    sb.push_back(24'h887799);
    sb.push_back(24'hFF0000);
    tick_n(2);
    pulse_show;
    wait_done("wr frame2 done");
    tick_n(2);

    // Asynchronous reset while a pixel sits in SEND.
    tx_ready = 1'b0;
    pulse_show;
    wait_valid("rst mid valid");
    #2 rst_n = 1'b0;
    #1;
    check("rst mid tx_valid", 32'(tx_valid), 32'd0);
    check("rst mid busy", 32'(busy), 32'd0);
    check("rst mid frame_done", 32'(frame_done), 32'd0);
    check("rst mid tx_grb", 32'(tx_grb), 32'd0);
    tick_n(3);
    rst_n = 1'b1;
    tick_n(3);
    check("post rst busy", 32'(busy), 32'd0);
    check("post rst valid", 32'(tx_valid), 32'd0);
    load4(24'h0A0B0C, 24'h102030, 24'h405060, 24'h708090);
    tx_ready = 1'b1;
    sb.push_back(24'h0B0A0C);
    sb.push_back(24'h201030);
    sb.push_back(24'h504060);
    sb.push_back(24'h807090);
    pulse_show;
    wait_done("post rst frame");
    tick_n(2);
    check("final sb empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
